ex_div_unit: RTL and testbench

//  Multi-cycle integer divide unit in the EX stage: the consumer end of the ID->EX

---
 rtl/ex_div_unit.sv | 122 ++++++++++++
 tb/tb_ex_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// EX-stage radix-2 restoring divider: accepts one div/mod op over a valid/ready
// handshake, iterates DATA_WIDTH cycles, then holds the result until EX/MEM takes it.
//
// state | meaning
// IDLE  | no op held, ready to accept
// CALC  | iterating, one quotient bit per cycle, then sign fix
// DONE  | result presented, waiting for ns_ready
module ex_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ls_valid,
  output logic                  ts_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [1:0]            div_op,
  input  logic [TAG_WIDTH-1:0]  rw_addr_i,
  output logic                  ts_valid,
  input  logic                  ns_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  rw_addr_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   quo;
  logic [W:0]     rem;
  logic [W-1:0]   dvsr;
  logic           op_mod;
  logic           neg_a;
  logic           neg_q;
  logic           dz;

  logic           accept;
  logic           sgn;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic           ge;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  assign ts_ready = (state == IDLE) || (state == DONE && ns_ready);
  assign ts_valid = (state == DONE);
  assign accept   = ls_valid && ts_ready && !flush;

  assign sgn   = !div_op[1];
  assign a_mag = (sgn && dividend[W-1]) ? -dividend : dividend;
  assign b_mag = (sgn && divisor[W-1])  ? -divisor  : divisor;

  // rem[W] stays zero (partial remainder is always below the divisor); folding it
  // into ge keeps the top bit meaningful without changing the arithmetic.
  assign shifted = {rem[W-1:0], quo[W-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign ge      = rem[W] || (shifted >= {1'b0, dvsr});

  // Divide-by-zero: all-ones quotient; the remainder path already holds |dividend|.
  assign q_fix = dz ? '1 : (neg_q ? -quo : quo);
  assign r_fix = neg_a ? -rem[W-1:0] : rem[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (ls_valid) state_nx = CALC;
        CALC:    if (cnt == '0) state_nx = DONE;
        DONE:    if (ns_ready) state_nx = ls_valid ? CALC : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      op_mod    <= 1'b0;
      neg_a     <= 1'b0;
      neg_q     <= 1'b0;
      dz        <= 1'b0;
      result    <= '0;
      rw_addr_o <= '0;
    end else if (accept) begin
      cnt       <= CW'(DATA_WIDTH);
      quo       <= a_mag;
      rem       <= '0;
      dvsr      <= b_mag;
      op_mod    <= div_op[0];
      neg_a     <= sgn && dividend[W-1];
      neg_q     <= sgn && (dividend[W-1] ^ divisor[W-1]);
      dz        <= (divisor == '0);
      rw_addr_o <= rw_addr_i;
    end else if (state == CALC && !flush) begin
      if (cnt == '0) begin
        result <= op_mod ? r_fix : q_fix;
      end else begin
        quo <= {quo[W-2:0], ge};
        rem <= ge ? diff : shifted;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected results are queued at accept and
// compared when EX/MEM takes them, with latency, stall, flush and reset scenarios.
module tb_ex_div_unit;
  localparam int W   = 32;
  localparam int T   = 5;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, flush, ls_valid, ns_ready;
  logic         ts_ready, ts_valid;
  logic [W-1:0] dividend, divisor, result;
  logic [1:0]   div_op;
  logic [T-1:0] rw_addr_i, rw_addr_o;

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_take = -1;
  int   last_acc = -2;
  logic tv_prev = 1'b0;

  ex_div_unit #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ls_valid(ls_valid), .ts_ready(ts_ready),
    .dividend(dividend), .divisor(divisor), .div_op(div_op), .rw_addr_i(rw_addr_i),
    .ts_valid(ts_valid), .ns_ready(ns_ready), .result(result), .rw_addr_o(rw_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic signed [W-1:0] sa, sbv;
    logic [W-1:0] q, r;
    sa = a;
    sbv = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!op[1]) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = sa / sbv;
        r = sa % sbv;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ts_valid && !tv_prev && sb.size() > 0)
        check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
      if (ts_valid && ns_ready) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("rw_addr_o", 64'(rw_addr_o), 64'(e.tag));
          last_take = cyc + 1;
        end
      end
      if (ls_valid && ts_ready && !flush) begin
        e.res = model(dividend, divisor, div_op);
        e.tag = rw_addr_i;
        e.acc = cyc + 1;
        sb.push_back(e);
        last_acc = cyc + 1;
      end
    end
    tv_prev = ts_valid;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [T-1:0] tag);
    bit ok = 0;
    dividend = a; divisor = b; div_op = op; rw_addr_i = tag; ls_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ts_ready && !flush) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    ls_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; div_op = 2'($urandom); rw_addr_i = T'($urandom);
  endtask

  task automatic drain(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ts_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ts_valid) begin ok = 1; break; end
    end
    if (!ok) check("valid_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ls_valid = 1'b0; ns_ready = 1'b1;
    dividend = '0; divisor = '0; div_op = 2'b00; rw_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ts_valid", 64'(ts_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_rw_addr_o", 64'(rw_addr_o), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_ts_ready", 64'(ts_ready), 64'(1));
    @(posedge clk); #1;

    issue(32'd100, 32'd7, 2'b00, 5'd3);
    drain(60);

    issue(32'hFFFF_FFF9, 32'd2, 2'b01, 5'd4);
    issue(32'hFFFF_FFFF, 32'd2, 2'b10, 5'd5);
    drain(100);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 5'd6);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 5'd7);
    issue(32'd1234, 32'd0, 2'b00, 5'd8);
    issue(32'hFFFF_FF00, 32'd0, 2'b01, 5'd9);
    issue(32'hDEAD_BEEF, 32'd0, 2'b10, 5'd10);
    issue(32'hDEAD_BEEF, 32'd0, 2'b11, 5'd11);
    drain(300);

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] b;
      b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 20)) : W'($urandom);
      issue(W'($urandom), b, 2'($urandom), T'($urandom));
    end
    drain(400);

    // Stall in DONE with a pending op on ID_EX, then release into a back-to-back accept.
    ns_ready = 1'b0;
    issue(32'd1000, 32'hFFFF_FFFD, 2'b00, 5'd12);
    wait_valid(60);
    @(posedge clk); #1;
    dividend = 32'd77; divisor = 32'd5; div_op = 2'b01; rw_addr_i = 5'd13; ls_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ts_valid", 64'(ts_valid), 64'(1));
      check("stall_ts_ready", 64'(ts_ready), 64'(0));
      check("stall_result", 64'(result), 64'(32'hFFFF_FEB3));
      check("stall_rw_addr_o", 64'(rw_addr_o), 64'(12));
    end
    @(posedge clk); #1;
    ns_ready = 1'b1;
    issue(32'd77, 32'd5, 2'b01, 5'd13);
    check("b2b_same_edge", 64'(last_take), 64'(last_acc));
    drain(60);

    // flush mid-CALC, with a simultaneous ls_valid that must not be accepted
    issue(32'd500, 32'd7, 2'b00, 5'd14);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; ls_valid = 1'b1; dividend = 32'd9; divisor = 32'd3; rw_addr_i = 5'd15;
    @(posedge clk); #1;
    flush = 1'b0; ls_valid = 1'b0;
    sb.delete();
    check("flush_idle_ready", 64'(ts_ready), 64'(1));
    check("flush_ts_valid", 64'(ts_valid), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    issue(32'hFFFF_FFD3, 32'd7, 2'b00, 5'd16);
    drain(60);

    // async reset mid-CALC
    issue(32'd999, 32'd10, 2'b01, 5'd17);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_calc_idle", 64'(ts_ready), 64'(1));
    check("rst_calc_result", 64'(result), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(32'd81, 32'd9, 2'b10, 5'd18);
    drain(60);

    // async reset while a result is held in DONE
    ns_ready = 1'b0;
    issue(32'd55, 32'd4, 2'b00, 5'd19);
    wait_valid(60);
    #2;
    rst = 1'b1;
    #1;
    check("rst_done_ts_valid", 64'(ts_valid), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ns_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFE, 2'b01, 5'd20);
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
